sec02_stream_accumulator: RTL

//   Latency-insensitive accumulator placed directly downstream of the sec02 adder.

---
 rtl/sec02_stream_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sec02_stream_accumulator.sv
// Val/rdy accumulator: sums each group of p_count input messages and emits one total per group.
// Optional build macro SEC02_ACCUM_SATURATE_EN selects a saturating add instead of wrap-around.
module sec02_stream_accumulator #(
  parameter int unsigned p_nbits = 32,
  parameter int unsigned p_count = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int unsigned CW = $clog2(p_count + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(p_count - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [p_nbits-1:0] acc_r;
  logic [p_nbits-1:0] acc_next_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_next_s;
  logic               in_xfer_s;
  logic               out_xfer_s;

  function automatic logic [p_nbits-1:0] accum_add(
    input logic [p_nbits-1:0] a,
    input logic [p_nbits-1:0] b
  );
`ifdef SEC02_ACCUM_SATURATE_EN
    logic [p_nbits:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    if (wide[p_nbits]) begin
      return {p_nbits{1'b1}};
    end else begin
      return wide[p_nbits-1:0];
    end
`else
    return a + b;
`endif
  endfunction

  assign in_xfer_s   = istream_val && istream_rdy;
  assign out_xfer_s  = ostream_val && ostream_rdy;
  // The total is the accumulator register itself, so it stays stable while the sink stalls.
  assign ostream_msg = acc_r;

  // Handshake outputs decoded from the state register; both forced low during reset.
  always_comb begin
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    if (reset) begin
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          istream_rdy = 1'b1;
          ostream_val = 1'b0;
        end
        SEND: begin
          istream_rdy = ostream_rdy;
          ostream_val = 1'b1;
        end
        default: begin
          istream_rdy = 1'b0;
          ostream_val = 1'b0;
        end
      endcase
    end
  end

  // Next-state, accumulator and counter update.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ACC: begin
        if (in_xfer_s) begin
          acc_next_s = accum_add(acc_r, istream_msg);
          if (cnt_r == LAST_CNT) begin
            cnt_next_s   = {CW{1'b0}};
            state_next_s = SEND;
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          acc_next_s = acc_r;
        end
      end
      SEND: begin
        if (out_xfer_s && in_xfer_s) begin
          // Overlap the first input of the next group with the outgoing total.
          acc_next_s = istream_msg;
          if (p_count == 1) begin
            cnt_next_s   = {CW{1'b0}};
            state_next_s = SEND;
          end else begin
            cnt_next_s   = CW'(1);
            state_next_s = ACC;
          end
        end else if (out_xfer_s) begin
          acc_next_s   = {p_nbits{1'b0}};
          cnt_next_s   = {CW{1'b0}};
          state_next_s = ACC;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = ACC;
        acc_next_s   = {p_nbits{1'b0}};
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset discarding any partial or pending total.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ACC;
      acc_r   <= {p_nbits{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      acc_r   <= acc_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

endmodule
